mmss_timekeeper: RTL

- Single-clock minutes:seconds stopwatch core. It sits between the button/switch debouncing front end and the 7-segment display driver.
- It consumes one-cycle debounced button pulses and synchronized switch levels.
- It produces binary minutes/seconds plus blink qualifiers for the display stage.
- It replaces derived-clock counting with clock-enable strobes generated from clk.

---
 rtl/mmss_timekeeper_pkg.sv | 23 ++
 rtl/mmss_timekeeper_strobe_div.sv | 36 +++
 rtl/mmss_timekeeper.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mmss_timekeeper_pkg.sv
// Shared constants, run-state encoding and field helper for the mm:ss stopwatch.
// No ports; imported by mmss_timekeeper.
package mmss_pkg;

  localparam int unsigned FIELD_W = 6;
  localparam logic [FIELD_W-1:0] MAX_FIELD = 6'd59;

  // Divider defaults for the 100 MHz board clock
  localparam int unsigned TICK_DIV_DEF  = 100000000;
  localparam int unsigned ADJ_DIV_DEF   = 50000000;
  localparam int unsigned BLINK_DIV_DEF = 25000000;

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } runState_t;

  // Increment a minutes/seconds field mod 60; anything at or past 59 goes to 0
  function automatic logic [FIELD_W-1:0] incField(input logic [FIELD_W-1:0] v);
    return (v >= MAX_FIELD) ? '0 : v + FIELD_W'(1);
  endfunction

endpackage

// File: rtl/mmss_timekeeper_strobe_div.sv
// Clock-enable prescaler: counts 0..DIV-1 while en is high and flags the wrap cycle.
// Ports:
//   clk      - system clock
//   arst     - asynchronous active-high reset (count to 0)
//   en       - advance the count this cycle; count holds otherwise
//   clr      - synchronous clear of the count (wins over en)
//   strobe_c - combinational, high in the cycle the count sits at DIV-1 with en high
module strobe_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic arst,
  input  logic en,
  input  logic clr,
  output logic strobe_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // A pending clear suppresses the strobe so the count and the consumer agree
  assign strobe_c = en & ~clr & (cnt == LAST);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mmss_timekeeper.sv
// Minutes:seconds stopwatch core driven by clock-enable strobes derived from clk.
// Ports:
//   clk, arst    - system clock, asynchronous active-high reset
//   clr_pulse    - one-cycle clear of the time and both counting prescalers
//   pause_pulse  - one-cycle RUN/PAUSED toggle
//   sw_adj       - adjust mode level; sw_sel picks the field (0 min, 1 sec)
//   minutes      - current minutes 0..59
//   seconds      - current seconds 0..59
//   running      - high while in RUN
//   blink_min    - blank the minutes digits (adjusting minutes, blink phase on)
//   blink_sec    - blank the seconds digits (adjusting seconds, blink phase on)
//   tick         - one-cycle pulse with every applied 1 Hz count
module mmss_timekeeper
  import mmss_pkg::*;
#(
  parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
  parameter int unsigned ADJ_DIV   = ADJ_DIV_DEF,
  parameter int unsigned BLINK_DIV = BLINK_DIV_DEF
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       clr_pulse,
  input  logic       pause_pulse,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       blink_min,
  output logic       blink_sec,
  output logic       tick
);

  runState_t state;
  logic      secStrobe;
  logic      adjStrobe;
  logic      blinkStrobe;
  logic      blinkPhase;
  logic      secEn;
  logic      adjClr;

  // Normal counting only in RUN outside adjust; adjust prescaler parked at 0 when idle
  assign secEn  = (state == RUN) & ~sw_adj;
  assign adjClr = clr_pulse | ~sw_adj;

  strobe_div #(.DIV(TICK_DIV)) secDiv (
    .clk      (clk),
    .arst     (arst),
    .en       (secEn),
    .clr      (clr_pulse),
    .strobe_c (secStrobe)
  );

  strobe_div #(.DIV(ADJ_DIV)) adjDiv (
    .clk      (clk),
    .arst     (arst),
    .en       (sw_adj),
    .clr      (adjClr),
    .strobe_c (adjStrobe)
  );

  strobe_div #(.DIV(BLINK_DIV)) blinkDiv (
    .clk      (clk),
    .arst     (arst),
    .en       (1'b1),
    .clr      (1'b0),
    .strobe_c (blinkStrobe)
  );

  // Blink phase and registered blank qualifiers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      blinkPhase <= 1'b0;
      blink_min  <= 1'b0;
      blink_sec  <= 1'b0;
    end else begin
      if (blinkStrobe) begin
        blinkPhase <= ~blinkPhase;
      end
      blink_min <= sw_adj & ~sw_sel & blinkPhase;
      blink_sec <= sw_adj & sw_sel & blinkPhase;
    end
  end

  // Run/pause state plus time fields; clear beats any increment in the same cycle
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= RUN;
      running <= 1'b1;
      minutes <= '0;
      seconds <= '0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;

      if (clr_pulse) begin
        minutes <= '0;
        seconds <= '0;
      end else if (sw_adj) begin
        if (adjStrobe) begin
          if (sw_sel) begin
            seconds <= incField(seconds);
          end else begin
            minutes <= incField(minutes);
          end
        end
      end else if (secStrobe) begin
        tick <= 1'b1;
        if (seconds >= MAX_FIELD) begin
          seconds <= '0;
          minutes <= incField(minutes);
        end else begin
          seconds <= seconds + 6'd1;
        end
      end

      // A strobe in the same cycle was already applied above
      if (pause_pulse) begin
        state   <= (state == RUN) ? PAUSED : RUN;
        running <= (state == PAUSED);
      end
    end
  end

endmodule
